uart_cmd_dispatch: RTL and testbench

//  Parametrised UART command front-end: receives 8N1 serial bytes, matches them against a

---
 rtl/uart_cmd_dispatch_pkg.sv | 21 ++
 rtl/uart_bin2bcd_seq.sv | 58 +++++
 rtl/uart_cmd_dispatch.sv | 268 ++++++++++++++++++++++++++
 tb/tb_uart_cmd_dispatch.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_dispatch_pkg.sv
// Shared constants and FSM encodings for the UART command dispatcher.
//   OVERSAMPLE   : ticks per UART bit
//   ASCII_*      : characters emitted in a value report
//   rx_state_e   : receiver FSM states
//   rp_state_e   : report FSM states
package uart_cmd_dispatch_pkg;
  localparam int OVERSAMPLE = 16;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT
  } rx_state_e;

  typedef enum logic [2:0] {
    RP_IDLE, RP_LOAD, RP_CONV, RP_SEND_DIG, RP_SEND_SEP, RP_SEND_CR, RP_SEND_LF, RP_DONE
  } rp_state_e;
endpackage

// File: rtl/uart_bin2bcd_seq.sv
// Sequential double-dabble binary to BCD converter, one bit per clock.
//   i_clk, i_rst (sync, active-low)
//   i_start : load i_bin and begin conversion (VAL_W cycles)
//   o_done  : one-cycle pulse, o_bcd valid from this cycle until next start
//   o_bcd   : DIGITS packed BCD digits, most significant digit in the top nibble
module uart_bin2bcd_seq #(
  parameter int VAL_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [VAL_W-1:0]      i_bin,
  output logic                  o_done,
  output logic [DIGITS*4-1:0]   o_bcd
);
  localparam int CW = $clog2(VAL_W + 1);

  logic [VAL_W-1:0]    r_bin;
  logic [DIGITS*4-1:0] r_bcd;
  logic [DIGITS*4-1:0] w_adj;
  logic [CW-1:0]       r_cnt;
  logic                r_busy;

  // add-3 on every digit >= 5 before the shift
  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < DIGITS; d++)
      if (r_bcd[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_start) begin
        r_bin  <= i_bin;
        r_bcd  <= '0;
        r_cnt  <= CW'(VAL_W);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          o_done <= 1'b1;
        end
      end
    end
  end

  assign o_bcd = r_bcd;
endmodule

// File: rtl/uart_cmd_dispatch.sv
// UART command front-end: 8N1 receiver, command-character decoder and a
// decimal value reporter on the transmit side.
//   i_clk, i_rst (sync, active-low), i_rx (async serial in), o_tx (serial out)
//   i_values     : NUM_VAL packed values, value k at [VAL_W*k +: VAL_W]
//   o_cmd        : one-hot strobe per matched command character
//   o_cmd_report : strobe when REPORT_CHAR is received
//   o_rx_byte / o_rx_valid : last good byte and its strobe
//   o_frame_err  : strobe when a stop bit is sampled low
//   o_tx_busy    : report being converted or transmitted
module uart_cmd_dispatch
  import uart_cmd_dispatch_pkg::*;
#(
  parameter int                   CLK_HZ      = 100_000_000,
  parameter int                   BAUD        = 9600,
  parameter int                   NUM_CMD     = 11,
  parameter logic [8*NUM_CMD-1:0] CMD_CHARS   = "LHMScmrs123",
  parameter logic [7:0]           REPORT_CHAR = "@",
  parameter int                   VAL_W       = 16,
  parameter int                   NUM_VAL     = 1,
  parameter int                   DIGITS      = 5
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_rx,
  output logic                     o_tx,
  input  logic [NUM_VAL*VAL_W-1:0] i_values,
  output logic [NUM_CMD-1:0]       o_cmd,
  output logic                     o_cmd_report,
  output logic [7:0]               o_rx_byte,
  output logic                     o_rx_valid,
  output logic                     o_frame_err,
  output logic                     o_tx_busy
);
  localparam int         DIV     = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int         TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [3:0] OS_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] OS_MID  = 4'(OVERSAMPLE / 2 - 1);

  // ---------------- oversample tick ----------------
  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;
  assign w_tick = (r_tick_cnt == TW'(DIV - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst) r_tick_cnt <= '0;
    else        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
  end

  // ---------------- receiver ----------------
  logic      r_rx_s1, r_rx_s2;
  rx_state_e r_rx_state, w_rx_next;
  logic [3:0] r_rx_tcnt;
  logic [2:0] r_rx_bcnt;
  logic [7:0] r_rx_sh;
  logic       w_rx_bit_end;
  assign w_rx_bit_end = w_tick && (r_rx_tcnt == OS_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_state <= RX_IDLE;
    end else begin
      r_rx_s1    <= i_rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_state <= w_rx_next;
    end
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (!r_rx_s2) w_rx_next = RX_START;
      // re-check the start bit at its middle to reject glitches
      RX_START: if (w_tick && r_rx_tcnt == OS_MID) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_bit_end && r_rx_bcnt == 3'd7) w_rx_next = RX_STOP;
      RX_STOP:  if (w_rx_bit_end) w_rx_next = r_rx_s2 ? RX_IDLE : RX_WAIT;
      RX_WAIT:  if (r_rx_s2) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_rx_tcnt   <= '0;
      r_rx_bcnt   <= '0;
      r_rx_sh     <= '0;
      o_rx_byte   <= '0;
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
      // timing restarts on every state change; within DATA the 4-bit
      // counter wraps 15->0, which lands each sample at mid-bit
      if (r_rx_state != w_rx_next) r_rx_tcnt <= '0;
      else if (w_tick)             r_rx_tcnt <= r_rx_tcnt + 1'b1;
      if (r_rx_state == RX_DATA && w_rx_bit_end) begin
        r_rx_sh   <= {r_rx_s2, r_rx_sh[7:1]};
        r_rx_bcnt <= r_rx_bcnt + 1'b1;
      end
      if (r_rx_state == RX_STOP && w_rx_bit_end) begin
        if (r_rx_s2) begin
          o_rx_byte  <= r_rx_sh;
          o_rx_valid <= 1'b1;
        end else begin
          o_frame_err <= 1'b1;
        end
      end
    end
  end

  // ---------------- command decode ----------------
  logic [NUM_CMD-1:0] w_match;

  // descending scan so the lowest matching index is the one left standing
  always_comb begin
    w_match = '0;
    for (int i = NUM_CMD - 1; i >= 0; i--)
      if (o_rx_byte == CMD_CHARS[8*i +: 8]) begin
        w_match    = '0;
        w_match[i] = 1'b1;
      end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_cmd        <= '0;
      o_cmd_report <= 1'b0;
    end else begin
      o_cmd        <= o_rx_valid ? w_match : '0;
      o_cmd_report <= o_rx_valid && (o_rx_byte == REPORT_CHAR);
    end
  end

  // ---------------- report FSM ----------------
  rp_state_e                r_rp_state, w_rp_next;
  logic [NUM_VAL*VAL_W-1:0] r_snap;     // current value always in the low slot
  logic [2:0]               r_val_left;
  logic [DIGITS*4-1:0]      r_dig_sh;   // current digit always in the top nibble
  logic [4:0]               r_dig_left;
  logic                     r_conv_run;
  logic                     w_conv_start, w_conv_done;
  logic [DIGITS*4-1:0]      w_bcd;
  logic                     w_tx_req, w_tx_ack, w_tx_last, r_tx_active;
  logic [7:0]               w_tx_data;

  uart_bin2bcd_seq #(.VAL_W(VAL_W), .DIGITS(DIGITS)) u_bcd (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (w_conv_start),
    .i_bin   (r_snap[VAL_W-1:0]),
    .o_done  (w_conv_done),
    .o_bcd   (w_bcd)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) r_rp_state <= RP_IDLE;
    else        r_rp_state <= w_rp_next;
  end

  always_comb begin
    w_rp_next = r_rp_state;
    case (r_rp_state)
      RP_IDLE:     if (o_cmd_report) w_rp_next = RP_LOAD;
      RP_LOAD:     w_rp_next = RP_CONV;
      RP_CONV:     if (w_conv_done) w_rp_next = RP_SEND_DIG;
      RP_SEND_DIG: if (w_tx_ack && r_dig_left == 5'd1)
                     w_rp_next = (r_val_left == 3'd1) ? RP_SEND_CR : RP_SEND_SEP;
      RP_SEND_SEP: if (w_tx_ack) w_rp_next = RP_CONV;
      RP_SEND_CR:  if (w_tx_ack) w_rp_next = RP_SEND_LF;
      RP_SEND_LF:  if (w_tx_ack) w_rp_next = RP_DONE;
      RP_DONE:     if (!r_tx_active) w_rp_next = RP_IDLE;  // LF stop bit finished
      default:     w_rp_next = RP_IDLE;
    endcase
  end

  always_comb begin
    w_tx_req     = 1'b0;
    w_tx_data    = ASCII_ZERO;
    w_conv_start = 1'b0;
    case (r_rp_state)
      RP_CONV:     w_conv_start = !r_conv_run;
      RP_SEND_DIG: begin
        w_tx_req  = 1'b1;
        w_tx_data = ASCII_ZERO + {4'h0, r_dig_sh[DIGITS*4-1 -: 4]};
      end
      RP_SEND_SEP: begin w_tx_req = 1'b1; w_tx_data = ASCII_COMMA; end
      RP_SEND_CR:  begin w_tx_req = 1'b1; w_tx_data = ASCII_CR;    end
      RP_SEND_LF:  begin w_tx_req = 1'b1; w_tx_data = ASCII_LF;    end
      default:     ;
    endcase
  end

  assign o_tx_busy = (r_rp_state != RP_IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_snap     <= '0;
      r_val_left <= '0;
      r_dig_sh   <= '0;
      r_dig_left <= '0;
      r_conv_run <= 1'b0;
    end else begin
      case (r_rp_state)
        RP_LOAD: begin
          r_snap     <= i_values;
          r_val_left <= 3'(NUM_VAL);
        end
        RP_CONV: begin
          if (w_conv_start) r_conv_run <= 1'b1;
          if (w_conv_done) begin
            r_conv_run <= 1'b0;
            r_dig_sh   <= w_bcd;
            r_dig_left <= 5'(DIGITS);
          end
        end
        RP_SEND_DIG: if (w_tx_ack) begin
          r_dig_sh   <= r_dig_sh << 4;
          r_dig_left <= r_dig_left - 1'b1;
        end
        RP_SEND_SEP: if (w_tx_ack) begin
          r_snap     <= r_snap >> VAL_W;
          r_val_left <= r_val_left - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- transmitter ----------------
  logic [8:0] r_tx_sh;
  logic [3:0] r_tx_bit, r_tx_tcnt;

  // a new byte is taken on a tick when idle, or on the tick that ends the
  // current stop bit, so consecutive report bytes have no idle gap
  assign w_tx_last = r_tx_active && (r_tx_tcnt == OS_LAST) && (r_tx_bit == 4'd9);
  assign w_tx_ack  = w_tick && w_tx_req && (!r_tx_active || w_tx_last);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_tx        <= 1'b1;
      r_tx_active <= 1'b0;
      r_tx_sh     <= '1;
      r_tx_bit    <= '0;
      r_tx_tcnt   <= '0;
    end else if (w_tick) begin
      if (w_tx_ack) begin
        o_tx        <= 1'b0;
        r_tx_sh     <= {1'b1, w_tx_data};
        r_tx_bit    <= '0;
        r_tx_tcnt   <= '0;
        r_tx_active <= 1'b1;
      end else if (r_tx_active) begin
        r_tx_tcnt <= r_tx_tcnt + 1'b1;
        if (r_tx_tcnt == OS_LAST) begin
          if (r_tx_bit == 4'd9) begin
            r_tx_active <= 1'b0;
          end else begin
            o_tx     <= r_tx_sh[0];
            r_tx_sh  <= {1'b1, r_tx_sh[8:1]};
            r_tx_bit <= r_tx_bit + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_cmd_dispatch.sv
// Directed bench for uart_cmd_dispatch. Clock/baud are scaled so one UART
// bit is 64 clocks. dut1 uses the default command table with one value;
// dut2 reports two values and has a table with a duplicate entry.
module tb_uart_cmd_dispatch;
  localparam int BITC = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx1 = 1'b1, rx2 = 1'b1;
  logic tx1, tx2;
  logic [15:0] val1 = 16'h0;
  logic [31:0] val2 = 32'h0;
  logic [10:0] cmd1;
  logic [3:0]  cmd2;
  logic rep1, rep2, vld1, vld2, fe1, fe2, busy1, busy2;
  logic [7:0] rb1, rb2;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  uart_cmd_dispatch #(.CLK_HZ(1_600_000), .BAUD(25_000)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx1), .o_tx(tx1), .i_values(val1),
    .o_cmd(cmd1), .o_cmd_report(rep1), .o_rx_byte(rb1), .o_rx_valid(vld1),
    .o_frame_err(fe1), .o_tx_busy(busy1));

  uart_cmd_dispatch #(.CLK_HZ(1_600_000), .BAUD(25_000), .NUM_CMD(4),
                      .CMD_CHARS("xAyA"), .NUM_VAL(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx2), .o_tx(tx2), .i_values(val2),
    .o_cmd(cmd2), .o_cmd_report(rep2), .o_rx_byte(rb2), .o_rx_valid(vld2),
    .o_frame_err(fe2), .o_tx_busy(busy2));

  // strobe / activity counters (only ever incremented here)
  int c_cmd[11], c_cmd2[4];
  int c_multi = 0, c_rep = 0, c_vld = 0, c_fe = 0, c_txlow = 0;
  always @(posedge clk) begin
    for (int i = 0; i < 11; i++) if (cmd1[i] === 1'b1) c_cmd[i]++;
    for (int i = 0; i < 4; i++)  if (cmd2[i] === 1'b1) c_cmd2[i]++;
    if ($countones(cmd1) > 1) c_multi++;
    if (rep1 === 1'b1) c_rep++;
    if (vld1 === 1'b1) c_vld++;
    if (fe1 === 1'b1)  c_fe++;
    if (tx1 === 1'b0)  c_txlow++;
  end

  function automatic int cmd_sum();
    int s = 0;
    for (int i = 0; i < 11; i++) s += c_cmd[i];
    return s;
  endfunction

  function automatic logic txv(input int w);
    return (w == 1) ? tx1 : tx2;
  endfunction

  function automatic logic busyv(input int w);
    return (w == 1) ? busy1 : busy2;
  endfunction

  task automatic send_byte(input int w, input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (w == 1) rx1 = f[i]; else rx2 = f[i];
      repeat (BITC) @(negedge clk);
    end
    if (w == 1) rx1 = 1'b1; else rx2 = 1'b1;
    repeat (BITC) @(negedge clk);
  endtask

  // receive one 8N1 byte from a DUT tx line; ok=0 on timeout or bad framing
  task automatic get_tx(input int w, output logic [7:0] b, output logic ok);
    int t = 0;
    ok = 1'b0;
    b  = 8'h00;
    while (txv(w) !== 1'b0 && t < 20000) begin @(negedge clk); t++; end
    if (t >= 20000) return;
    repeat (BITC/2) @(negedge clk);
    if (txv(w) !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (BITC) @(negedge clk);
      b[i] = txv(w);
    end
    repeat (BITC) @(negedge clk);
    ok = (txv(w) === 1'b1);
  endtask

  task automatic get_report(input int w, input string exp, input string tag);
    logic [7:0] b;
    logic ok;
    logic busy_ok = 1'b1;
    for (int i = 0; i < exp.len(); i++) begin
      get_tx(w, b, ok);
      if (busyv(w) !== 1'b1) busy_ok = 1'b0;
      n_chk++;
      if (!ok || b !== exp[i])
        $display("FAIL %s_byte%0d: got 0x%02h framing_ok=%0b, want 0x%02h", tag, i, b, ok, exp[i]);
      else n_pass++;
      if (!ok) break;
    end
    n_chk++;
    if (!busy_ok) $display("FAIL %s_busy_during: tx_busy dropped inside the report, want 1", tag);
    else n_pass++;
    repeat (BITC) @(negedge clk);
    n_chk++;
    if (busyv(w) !== 1'b0) $display("FAIL %s_busy_after: got %b want 0", tag, busyv(w));
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_chk++; if (tx1 !== 1'b1)   $display("FAIL rst_tx: got %b want 1", tx1);           else n_pass++;
    n_chk++; if (busy1 !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy1);       else n_pass++;
    n_chk++; if (cmd1 !== 11'h0) $display("FAIL rst_cmd: got %h want 0", cmd1);         else n_pass++;
    n_chk++; if (rep1 !== 1'b0)  $display("FAIL rst_report: got %b want 0", rep1);      else n_pass++;
    n_chk++; if (rb1 !== 8'h00)  $display("FAIL rst_rx_byte: got %h want 00", rb1);     else n_pass++;
    n_chk++; if (vld1 !== 1'b0)  $display("FAIL rst_rx_valid: got %b want 0", vld1);    else n_pass++;
    n_chk++; if (fe1 !== 1'b0)   $display("FAIL rst_frame_err: got %b want 0", fe1);    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // table index i is character CMD_CHARS[8*i+:8]: '3'->0, 'c'->6, 'L'->10
  task automatic test_cmd_decode();
    int s[11];
    logic [10:0] exp_hits;
    int s_multi, s_rep;
    s = c_cmd; s_multi = c_multi; s_rep = c_rep;
    exp_hits = 11'b100_0100_0001;
    send_byte(1, "L", 1'b1);
    send_byte(1, "c", 1'b1);
    send_byte(1, "3", 1'b1);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      n_chk++;
      if (c_cmd[i] - s[i] !== int'(exp_hits[i]))
        $display("FAIL cmd_hits[%0d]: got %0d cycles want %0d", i, c_cmd[i] - s[i], exp_hits[i]);
      else n_pass++;
    end
    n_chk++; if (c_multi != s_multi) $display("FAIL cmd_multihot: got %0d want 0", c_multi - s_multi); else n_pass++;
    n_chk++; if (c_rep != s_rep) $display("FAIL cmd_no_report: got %0d want 0", c_rep - s_rep); else n_pass++;
    n_chk++; if (rb1 !== 8'h33) $display("FAIL cmd_rx_byte: got %h want 33", rb1); else n_pass++;
  endtask

  task automatic test_dup_table();
    int s[4];
    s = c_cmd2;
    send_byte(2, "A", 1'b1);
    send_byte(2, "y", 1'b1);
    repeat (4) @(negedge clk);
    n_chk++; if (c_cmd2[0] - s[0] != 1) $display("FAIL dup_low: got %0d want 1", c_cmd2[0] - s[0]); else n_pass++;
    n_chk++; if (c_cmd2[2] - s[2] != 0) $display("FAIL dup_high: got %0d want 0", c_cmd2[2] - s[2]); else n_pass++;
    n_chk++; if (c_cmd2[1] - s[1] != 1) $display("FAIL dup_y: got %0d want 1", c_cmd2[1] - s[1]); else n_pass++;
  endtask

  task automatic test_report_single();
    int s_rep;
    s_rep = c_rep;
    val1 = 16'h0342;
    fork
      send_byte(1, "@", 1'b1);
      get_report(1, "00834\r\n", "rpt1");
    join
    n_chk++; if (c_rep - s_rep != 1) $display("FAIL rpt1_report_strobe: got %0d want 1", c_rep - s_rep); else n_pass++;
  endtask

  task automatic test_report_two_values();
    val2 = {16'hFFFF, 16'h0000};
    fork
      send_byte(2, "@", 1'b1);
      get_report(2, "00000,65535\r\n", "rpt2");
      begin
        repeat (1200) @(negedge clk);
        val2 = 32'h1234_5678;
      end
    join
  endtask

  task automatic test_frame_error();
    int s_fe, s_vld, s_sum, s_h;
    s_fe = c_fe; s_vld = c_vld; s_sum = cmd_sum(); s_h = c_cmd[9];
    send_byte(1, "H", 1'b0);
    n_chk++; if (c_fe - s_fe != 1)   $display("FAIL ferr_pulse: got %0d want 1", c_fe - s_fe); else n_pass++;
    n_chk++; if (c_vld != s_vld)     $display("FAIL ferr_no_valid: got %0d want 0", c_vld - s_vld); else n_pass++;
    n_chk++; if (cmd_sum() != s_sum) $display("FAIL ferr_no_cmd: got %0d want 0", cmd_sum() - s_sum); else n_pass++;
    send_byte(1, "H", 1'b1);
    repeat (4) @(negedge clk);
    n_chk++; if (c_cmd[9] - s_h != 1) $display("FAIL ferr_next_H: got %0d want 1", c_cmd[9] - s_h); else n_pass++;
    n_chk++; if (rb1 !== 8'h48) $display("FAIL ferr_rx_byte: got %h want 48", rb1); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int s_rep, s_low;
    s_rep = c_rep;
    val1 = 16'h0342;
    fork
      begin
        send_byte(1, "@", 1'b1);
        send_byte(1, "@", 1'b1);
      end
      get_report(1, "00834\r\n", "b2b");
    join
    n_chk++; if (c_rep - s_rep != 2) $display("FAIL b2b_report_strobes: got %0d want 2", c_rep - s_rep); else n_pass++;
    s_low = c_txlow;
    repeat (2000) @(negedge clk);
    n_chk++; if (c_txlow != s_low) $display("FAIL b2b_second_report: tx low %0d cycles want 0", c_txlow - s_low); else n_pass++;
    n_chk++; if (busy1 !== 1'b0) $display("FAIL b2b_busy_idle: got %b want 0", busy1); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int s_vld, s_sum, s_rep, s_fe, s_low;
    val1 = 16'h0342;
    send_byte(1, "@", 1'b1);
    fork
      send_byte(1, 8'hF0, 1'b1);
      begin
        repeat (BITC*5 + BITC/2) @(negedge clk);
        n_chk++; if (busy1 !== 1'b1) $display("FAIL rmid_busy_before: got %b want 1", busy1); else n_pass++;
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_chk++; if (tx1 !== 1'b1)   $display("FAIL rmid_tx: got %b want 1", tx1); else n_pass++;
        n_chk++; if (busy1 !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy1); else n_pass++;
        n_chk++; if (rb1 !== 8'h00)  $display("FAIL rmid_rx_byte: got %h want 00", rb1); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        s_vld = c_vld; s_sum = cmd_sum(); s_rep = c_rep; s_fe = c_fe; s_low = c_txlow;
      end
    join
    repeat (1500) @(negedge clk);
    n_chk++; if (c_vld != s_vld)     $display("FAIL rmid_no_valid: got %0d want 0", c_vld - s_vld); else n_pass++;
    n_chk++; if (cmd_sum() != s_sum) $display("FAIL rmid_no_cmd: got %0d want 0", cmd_sum() - s_sum); else n_pass++;
    n_chk++; if (c_rep != s_rep)     $display("FAIL rmid_no_report: got %0d want 0", c_rep - s_rep); else n_pass++;
    n_chk++; if (c_fe != s_fe)       $display("FAIL rmid_no_ferr: got %0d want 0", c_fe - s_fe); else n_pass++;
    n_chk++; if (c_txlow != s_low)   $display("FAIL rmid_tx_idle: tx low %0d cycles want 0", c_txlow - s_low); else n_pass++;
    n_chk++; if (busy1 !== 1'b0)     $display("FAIL rmid_busy_after: got %b want 0", busy1); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 11; i++) c_cmd[i] = 0;
    for (int i = 0; i < 4; i++)  c_cmd2[i] = 0;
    test_reset();
    test_cmd_decode();
    test_dup_table();
    test_report_single();
    test_report_two_values();
    test_frame_error();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_chk);
    $fatal(1, "watchdog");
  end
endmodule
